memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the data-memory depth in 32-bit words (power of two, 2..1024).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in, input, 1 bit: the execute-stage outputs carry a live instruction.
REQ-005 SHALL have port ALUResult, input, 32 bits: the effective address for loads and stores, or the ALU value for writeback.
REQ-006 SHALL have port ALUReadData2, input, 32 bits: the store data.
REQ-007 SHALL have ports RdOrRt (input, 5 bits: destination register), zero (input, 1 bit: ALU zero flag) and AddResult (input, 32 bits: branch target).
REQ-008 SHALL have control inputs MemRead, MemWrite, Branch, RegWrite and MemtoReg, each 1 bit.
REQ-009 SHALL have port hold, input, 1 bit: downstream stall; this stage freezes while it is 1.
REQ-010 SHALL have outputs PCSrc (1 bit: branch taken) and BranchTarget (32 bits).
REQ-011 SHALL have outputs wb_valid, wb_RegWrite, wb_MemtoReg and wb_fault, each 1 bit.
REQ-012 SHALL have outputs wb_ReadData (32 bits), wb_ALUResult (32 bits) and wb_RdOrRt (5 bits).

Function
REQ-013 SHALL drive PCSrc combinationally as valid_in AND Branch AND zero, independent of hold.
REQ-014 SHALL drive BranchTarget combinationally equal to AddResult.
REQ-015 SHALL form the word index from ALUResult[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-016 SHALL define "misaligned" as valid_in AND (MemRead OR MemWrite) AND ALUResult[1:0] not equal to 0.
REQ-017 SHALL write ALUReadData2 into memory at the rising edge when valid_in AND MemWrite AND NOT hold AND NOT misaligned.
REQ-018 SHALL have a load latency of exactly one cycle: the word addressed at edge N appears on wb_ReadData after edge N.
REQ-019 SHALL, when MemRead and MemWrite are both 1, perform the write and present the store data on wb_ReadData (write-first).
REQ-020 SHALL, for a load in the cycle after a store to the same word, return the newly stored data.
REQ-021 SHALL, on each edge with hold=0, register: wb_valid=valid_in; wb_ALUResult=ALUResult; wb_RdOrRt=RdOrRt; wb_MemtoReg=MemtoReg; wb_RegWrite=valid_in AND RegWrite AND NOT misaligned; wb_fault=misaligned.
REQ-022 SHALL, when not loading, hold wb_ReadData at its previous value.
REQ-023 SHALL, on each edge with hold=1, keep every wb_* register and all memory contents unchanged.
REQ-024 SHALL, when valid_in=0, perform no memory write, set wb_RegWrite=0 and set wb_fault=0, even if control inputs are nonzero.
REQ-025 SHALL NOT cause a misaligned access to write memory; wb_fault SHALL pulse for exactly one unstalled cycle per faulting instruction.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear wb_valid, wb_RegWrite, wb_MemtoReg, wb_fault, wb_ReadData, wb_ALUResult and wb_RdOrRt to 0.
REQ-027 SHALL NOT reset data-memory contents; a load of a never-written word returns an unspecified value.
REQ-028 SHALL abandon any in-flight store when reset is asserted mid-cycle: no memory write on the edge where rst_n=0.
REQ-029 SHALL take its first capture on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL take the default DEPTH and the 32-bit data-width constant from the shared pipeline package; the MEM/WB field bundle SHALL be a package typedef shared with the writeback stage.
REQ-031 SHALL place the memory array in one sub-module, data_memory, with one synchronous write port and one synchronous read port; pipeline registers and fault logic stay in memory_stage.

Verification
REQ-032 SHALL verify store then load: store 0xDEADBEEF at address 0x10, then load 0x10 next cycle -> wb_ReadData=0xDEADBEEF, wb_MemtoReg=1, wb_RegWrite=1.
REQ-033 SHALL verify branch: valid_in=1, Branch=1, zero=1, AddResult=0x40 -> PCSrc=1 and BranchTarget=0x40 in the same cycle; with zero=0 -> PCSrc=0.
REQ-034 SHALL verify misalignment: store at 0x13 -> word 4 unchanged on readback, wb_fault=1 for one cycle, wb_RegWrite=0.
REQ-035 SHALL verify hold: assert hold for 3 cycles with a store pending -> wb_* outputs frozen and no write; on release -> exactly one write.
REQ-036 SHALL verify wrap: with DEPTH=256, store 0x11 to 0x400, then load 0x000 -> 0x11.
REQ-037 SHALL verify reset mid-store: drop rst_n during a store cycle -> all wb_* outputs are 0 immediately and the target word keeps its old value.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared pipeline types and constants for the memory and writeback stages.
// Latency: none (declarations only).
// Backpressure: not applicable.
package memory_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int DMEM_DEPTH = 256;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [4:0]        reg_idx_t;

    // Registered MEM/WB control and pass-through fields
    typedef struct packed {
        logic     valid;
        logic     RegWrite;
        logic     MemtoReg;
        logic     fault;
        word_t    ALUResult;
        reg_idx_t RdOrRt;
    } mem_wb_ctl_t;

    // Full MEM/WB bundle as seen by the writeback stage
    typedef struct packed {
        mem_wb_ctl_t ctl;
        word_t       ReadData;
    } mem_wb_t;

    // Word accesses need the two byte-offset bits clear
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-memory inputs and memory-to-writeback outputs of the memory stage.
// Latency: none (wiring only).
// Backpressure: hold travels with the bundle from the downstream side.
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic     valid_in;
    word_t    ALUResult;
    word_t    ALUReadData2;
    reg_idx_t RdOrRt;
    logic     zero;
    word_t    AddResult;
    logic     MemRead;
    logic     MemWrite;
    logic     Branch;
    logic     RegWrite;
    logic     MemtoReg;
    logic     hold;

    logic     PCSrc;
    word_t    BranchTarget;
    logic     wb_valid;
    logic     wb_RegWrite;
    logic     wb_MemtoReg;
    logic     wb_fault;
    word_t    wb_ReadData;
    word_t    wb_ALUResult;
    reg_idx_t wb_RdOrRt;

    modport master (
        output valid_in, ALUResult, ALUReadData2, RdOrRt, zero, AddResult,
               MemRead, MemWrite, Branch, RegWrite, MemtoReg, hold,
        input  PCSrc, BranchTarget, wb_valid, wb_RegWrite, wb_MemtoReg,
               wb_fault, wb_ReadData, wb_ALUResult, wb_RdOrRt
    );

    modport slave (
        input  valid_in, ALUResult, ALUReadData2, RdOrRt, zero, AddResult,
               MemRead, MemWrite, Branch, RegWrite, MemtoReg, hold,
        output PCSrc, BranchTarget, wb_valid, wb_RegWrite, wb_MemtoReg,
               wb_fault, wb_ReadData, wb_ALUResult, wb_RdOrRt
    );

endinterface

// File: rtl/memory_stage_dmem.sv
// Word-wide data memory: one synchronous write port, one registered read port.
// Latency: read data valid one cycle after re_i; a same-cycle write is forwarded (write-first).
// Backpressure: none; caller gates we_i/re_i, and rdata_o holds while re_i is low.
module data_memory
    import memory_stage_pkg::*;
#(
    parameter int  DEPTH = DMEM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register; a colliding write wins so a store-and-load sees its own data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data-memory access, branch resolution and the MEM/WB pipeline register.
// Latency: PCSrc/BranchTarget combinational; load data and wb_* fields one cycle after capture.
// Backpressure: hold=1 freezes the MEM/WB register and blocks memory reads and writes.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    memory_stage_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] word_idx;
    logic          misaligned;
    logic          mem_we;
    logic          mem_re;
    word_t         rdata;
    mem_wb_ctl_t   wb_d;
    mem_wb_ctl_t   wb_q;
    mem_wb_t       wb_bundle;

    // Upper address bits are dropped, so addresses alias modulo the memory size
    assign word_idx   = bus.ALUResult[AW+1:2];
    assign misaligned = bus.valid_in & (bus.MemRead | bus.MemWrite)
                      & is_misaligned(bus.ALUResult[1:0]);

    // rst_n gates the write so a store in flight when reset lands is dropped
    assign mem_we = bus.valid_in & bus.MemWrite & ~bus.hold & ~misaligned & rst_n;
    assign mem_re = bus.valid_in & bus.MemRead & ~bus.hold;

    assign bus.PCSrc        = bus.valid_in & bus.Branch & bus.zero;
    assign bus.BranchTarget = bus.AddResult;

    data_memory #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (word_idx),
        .wdata_i (bus.ALUReadData2),
        .rdata_o (rdata)
    );

    // Next MEM/WB contents; a stalled cycle keeps the current contents
    always_comb begin
        wb_d = wb_q;
        if (!bus.hold) begin
            wb_d.valid     = bus.valid_in;
            wb_d.RegWrite  = bus.valid_in & bus.RegWrite & ~misaligned;
            wb_d.MemtoReg  = bus.MemtoReg;
            wb_d.fault     = misaligned;
            wb_d.ALUResult = bus.ALUResult;
            wb_d.RdOrRt    = bus.RdOrRt;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_bundle = '{ctl: wb_q, ReadData: rdata};

    assign bus.wb_valid     = wb_bundle.ctl.valid;
    assign bus.wb_RegWrite  = wb_bundle.ctl.RegWrite;
    assign bus.wb_MemtoReg  = wb_bundle.ctl.MemtoReg;
    assign bus.wb_fault     = wb_bundle.ctl.fault;
    assign bus.wb_ALUResult = wb_bundle.ctl.ALUResult;
    assign bus.wb_RdOrRt    = wb_bundle.ctl.RdOrRt;
    assign bus.wb_ReadData  = wb_bundle.ReadData;

endmodule

// File: tb/tb_memory_stage.sv
// Randomised scoreboard bench for memory_stage against a word-array reference model.
// Latency: expectations are queued at drive time and popped one edge later.
// Backpressure: hold is exercised directly and at random.
module tb_memory_stage;

    localparam int DEPTH = 256;

    typedef struct {
        bit          v, mr, mw, br, rw, m2r, zero, hold;
        logic [31:0] addr, wdata, target;
        logic [4:0]  rd;
    } stim_t;

    typedef struct {
        logic        pcsrc;
        logic [31:0] target;
        logic        valid, rw, m2r, fault;
        logic [31:0] rdata;
        bit          rknown;
        logic [31:0] alu;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;

    memory_stage_if bus ();

    memory_stage #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    exp_t        scb_q[$];
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    exp_t        st;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.mr = 0; s.mw = 0; s.br = 0; s.rw = 0; s.m2r = 0; s.zero = 0; s.hold = 0;
        s.addr = '0; s.wdata = '0; s.target = '0; s.rd = '0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.valid_in     = s.v;
        bus.MemRead      = s.mr;
        bus.MemWrite     = s.mw;
        bus.Branch       = s.br;
        bus.RegWrite     = s.rw;
        bus.MemtoReg     = s.m2r;
        bus.zero         = s.zero;
        bus.hold         = s.hold;
        bus.ALUResult    = s.addr;
        bus.ALUReadData2 = s.wdata;
        bus.AddResult    = s.target;
        bus.RdOrRt       = s.rd;
    endtask

    // One cycle of stimulus: drive, advance the model, queue the expectation
    task automatic step(input stim_t s);
        bit   mis;
        int   idx;
        exp_t e;
        @(negedge clk);
        drive(s);
        mis = s.v && (s.mr || s.mw) && (s.addr % 4 != 0);
        idx = int'((s.addr / 4) % DEPTH);
        if (!s.hold) begin
            if (s.v && s.mw && !mis) begin
                mdl_mem[idx]   = s.wdata;
                mdl_known[idx] = 1'b1;
            end
            if (s.v && s.mr) begin
                st.rdata  = mdl_mem[idx];
                st.rknown = mdl_known[idx];
            end
            st.valid = s.v;
            st.rw    = s.v && s.rw && !mis;
            st.m2r   = s.m2r;
            st.fault = mis;
            st.alu   = s.addr;
            st.rd    = s.rd;
        end
        e        = st;
        e.pcsrc  = s.v && s.br && s.zero;
        e.target = s.target;
        scb_q.push_back(e);
    endtask

    function automatic stim_t st_store(input logic [31:0] a, input logic [31:0] d);
        stim_t s = idle();
        s.v = 1; s.mw = 1; s.addr = a; s.wdata = d;
        return s;
    endfunction

    function automatic stim_t st_load(input logic [31:0] a);
        stim_t s = idle();
        s.v = 1; s.mr = 1; s.rw = 1; s.m2r = 1; s.addr = a; s.rd = 5'd9;
        return s;
    endfunction

    task automatic check_wb_zero(input string tag);
        chk({tag, "_wb_valid"},     {31'd0, bus.wb_valid},    32'd0);
        chk({tag, "_wb_RegWrite"},  {31'd0, bus.wb_RegWrite}, 32'd0);
        chk({tag, "_wb_MemtoReg"},  {31'd0, bus.wb_MemtoReg}, 32'd0);
        chk({tag, "_wb_fault"},     {31'd0, bus.wb_fault},    32'd0);
        chk({tag, "_wb_ReadData"},  bus.wb_ReadData,          32'd0);
        chk({tag, "_wb_ALUResult"}, bus.wb_ALUResult,         32'd0);
        chk({tag, "_wb_RdOrRt"},    {27'd0, bus.wb_RdOrRt},   32'd0);
    endtask

    // Monitor: each edge, compare the DUT against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scb_q.size() > 0) begin
                e = scb_q.pop_front();
                chk("PCSrc",        {31'd0, bus.PCSrc},       {31'd0, e.pcsrc});
                chk("BranchTarget", bus.BranchTarget,         e.target);
                chk("wb_valid",     {31'd0, bus.wb_valid},    {31'd0, e.valid});
                chk("wb_RegWrite",  {31'd0, bus.wb_RegWrite}, {31'd0, e.rw});
                chk("wb_MemtoReg",  {31'd0, bus.wb_MemtoReg}, {31'd0, e.m2r});
                chk("wb_fault",     {31'd0, bus.wb_fault},    {31'd0, e.fault});
                chk("wb_ALUResult", bus.wb_ALUResult,         e.alu);
                chk("wb_RdOrRt",    {27'd0, bus.wb_RdOrRt},   {27'd0, e.rd});
                if (e.rknown) chk("wb_ReadData", bus.wb_ReadData, e.rdata);
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = 1'b0;
        end
        st = '{default: '0};
        st.rknown = 1'b1;

        rst_n = 1'b0;
        drive(idle());
        #12;
        check_wb_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load the same word on the next cycle
        step(st_store(32'h10, 32'hDEADBEEF));
        step(st_load(32'h10));

        // Branch taken, then not taken
        s = idle(); s.v = 1; s.br = 1; s.zero = 1; s.target = 32'h40;
        step(s);
        s.zero = 0;
        step(s);

        // Misaligned store must fault and leave word 4 untouched
        step(st_store(32'h13, 32'h55555555));
        step(st_load(32'h10));

        // Store stalled for three cycles, then released exactly once
        s = st_store(32'h20, 32'hA5A5A5A5); s.hold = 1;
        repeat (3) step(s);
        s.hold = 0;
        step(s);
        step(st_load(32'h20));

        // Address wrap: 0x400 aliases word 0
        step(st_store(32'h400, 32'h11));
        step(st_load(32'h000));

        // Simultaneous load and store returns the store data
        s = st_store(32'h30, 32'h12345678); s.mr = 1; s.rw = 1; s.m2r = 1;
        step(s);

        // Dead instruction with live-looking controls does nothing
        s = st_store(32'h10, 32'hBAD0BAD0); s.v = 0; s.rw = 1; s.mr = 1;
        step(s);
        step(st_load(32'h10));

        // Reset arriving during a store cycle
        @(negedge clk);
        drive(st_store(32'h20, 32'hCAFEF00D));
        #2;
        rst_n = 1'b0;
        #1;
        check_wb_zero("midrst");
        st = '{default: '0};
        st.rknown = 1'b1;
        @(negedge clk);
        drive(idle());
        rst_n = 1'b1;
        step(st_load(32'h20));

        // Randomised traffic over a small, aliased address window
        for (int n = 0; n < 600; n++) begin
            s = idle();
            s.v      = ($urandom_range(0, 7) != 0);
            s.mr     = $urandom_range(0, 1);
            s.mw     = $urandom_range(0, 1);
            s.br     = $urandom_range(0, 1);
            s.zero   = $urandom_range(0, 1);
            s.rw     = $urandom_range(0, 1);
            s.m2r    = $urandom_range(0, 1);
            s.hold   = ($urandom_range(0, 4) == 0);
            s.addr   = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) s.addr = s.addr | $urandom_range(1, 3);
            s.wdata  = $urandom;
            s.target = $urandom;
            s.rd     = 5'($urandom_range(0, 31));
            step(s);
        end

        @(negedge clk);
        drive(idle());
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
